// File: rtl/sram_pkg.sv
// Shared types and address helpers for the SRAM responder.
// Covers the default base address, the state enum, and the address decode.
package sram_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT  = 32'h1c00_0000;
  localparam int unsigned DEPTH_LOG2_DEFAULT = 12;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  // Word index in the low bits; the caller truncates to DEPTH_LOG2 bits.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned depth_log2);
    return (addr >> 2) & ((32'd1 << depth_log2) - 32'd1);
  endfunction

  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned depth_log2);
    return (addr >> (depth_log2 + 2)) == (base >> (depth_log2 + 2));
  endfunction

endpackage

// File: rtl/rd_pipe.sv
// Fixed-latency read-data pipeline: a Depth-stage 32-bit shift register.
// Synchronous active-high reset flushes every stage to zero.
module rd_pipe #(
  parameter int unsigned Depth = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] stage_q [Depth];
  logic [31:0] stage_d [Depth];

  always_comb begin
    stage_d[0] = d_i;
    for (int i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/sram_responder.sv
// Dual-port (inst/data) word memory responder with a post-reset clear sequencer.
// Reads are read-first through an RD_LAT pipeline; writes commit at the request edge.
module sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        ready,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  state_e      state_q, state_d;
  idx_t        clr_cnt_q, clr_cnt_d;
  logic        err_q, err_d;
  logic        clear_we;
  logic [31:0] mem_q [DEPTH];

  logic        inst_hit, data_hit;
  idx_t        inst_idx, data_idx;
  logic        inst_wr_en, data_wr_en;
  logic [31:0] inst_rd_d, data_rd_d;

  assign inst_hit = in_range(inst_sram_addr, BASE_ADDR, DEPTH_LOG2);
  assign data_hit = in_range(data_sram_addr, BASE_ADDR, DEPTH_LOG2);
  assign inst_idx = idx_t'(word_index(inst_sram_addr, DEPTH_LOG2));
  assign data_idx = idx_t'(word_index(data_sram_addr, DEPTH_LOG2));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      err_q     <= err_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + idx_t'(1);
        if (clr_cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: ;
      default: state_d = CLEAR;
    endcase
  end

  // Outputs and write/read enables
  always_comb begin
    ready      = (state_q == RUN);
    clear_we   = (state_q == CLEAR) && !reset;
    inst_wr_en = ready && inst_sram_we && inst_hit && !reset;
    data_wr_en = ready && data_sram_we && data_hit && !reset;
    err_d      = err_q | (ready & (~inst_hit | ~data_hit));
    inst_rd_d  = (ready && inst_hit) ? mem_q[inst_idx] : '0;
    data_rd_d  = (ready && data_hit) ? mem_q[data_idx] : '0;
  end

  assign addr_err = err_q;

  // Later assignment wins: data port takes priority on a same-word double write.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem_q[clr_cnt_q] <= '0;
    end
    if (inst_wr_en) begin
      mem_q[inst_idx] <= inst_sram_wdata;
    end
    if (data_wr_en) begin
      mem_q[data_idx] <= data_sram_wdata;
    end
  end

  rd_pipe #(
    .Depth(RD_LAT)
  ) u_inst_pipe (
    .clk  (clk),
    .reset(reset),
    .d_i  (inst_rd_d),
    .q_o  (inst_sram_rdata)
  );

  rd_pipe #(
    .Depth(RD_LAT)
  ) u_data_pipe (
    .clk  (clk),
    .reset(reset),
    .d_i  (data_rd_d),
    .q_o  (data_sram_rdata)
  );

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: one instance at RD_LAT=1, one at RD_LAT=3,
// both with DEPTH_LOG2=4 and driven by the same directed stimulus.
module tb_sram_responder;

  localparam logic [31:0] BASE = 32'h1c00_0000;
  localparam int unsigned MaxCycles = 2000;

  logic        clk;
  logic        reset;
  logic        inst_we, data_we;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata1, data_rdata1, inst_rdata3, data_rdata3;
  logic        ready1, ready3, err1, err3;

  sram_responder #(
    .DEPTH_LOG2(4),
    .BASE_ADDR (BASE),
    .RD_LAT    (1)
  ) dut1 (
    .clk            (clk),
    .reset          (reset),
    .inst_sram_we   (inst_we),
    .inst_sram_addr (inst_addr),
    .inst_sram_wdata(inst_wdata),
    .inst_sram_rdata(inst_rdata1),
    .data_sram_we   (data_we),
    .data_sram_addr (data_addr),
    .data_sram_wdata(data_wdata),
    .data_sram_rdata(data_rdata1),
    .ready          (ready1),
    .addr_err       (err1)
  );

  sram_responder #(
    .DEPTH_LOG2(4),
    .BASE_ADDR (BASE),
    .RD_LAT    (3)
  ) dut3 (
    .clk            (clk),
    .reset          (reset),
    .inst_sram_we   (inst_we),
    .inst_sram_addr (inst_addr),
    .inst_sram_wdata(inst_wdata),
    .inst_sram_rdata(inst_rdata3),
    .data_sram_we   (data_we),
    .data_sram_addr (data_addr),
    .data_sram_wdata(data_wdata),
    .data_sram_rdata(data_rdata3),
    .ready          (ready3),
    .addr_err       (err3)
  );

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog: the directed sequence must finish well within MaxCycles.
  initial begin
    repeat (MaxCycles) @(posedge clk);
    bad++;
    $display("FAIL timeout: test did not finish within %0d cycles", MaxCycles);
    $display("test done: total=%0d bad=%0d", total, bad);
    $display("TEST FAILED");
    $finish;
  end

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0:       return inst_rdata1;
      1:       return data_rdata1;
      2:       return inst_rdata3;
      3:       return data_rdata3;
      4:       return {31'b0, ready1};
      5:       return {31'b0, ready3};
      6:       return {31'b0, err1};
      default: return {31'b0, err3};
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      0:       return "inst_rdata_lat1";
      1:       return "data_rdata_lat1";
      2:       return "inst_rdata_lat3";
      3:       return "data_rdata_lat3";
      4:       return "ready_lat1";
      5:       return "ready_lat3";
      6:       return "addr_err_lat1";
      default: return "addr_err_lat3";
    endcase
  endfunction

  // Monitor: compare every entry that falls due this cycle.
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        act = pick(sb[i].sel);
        total++;
        if (sb[i].due != cyc || act !== sb[i].exp) begin
          bad++;
          $display("FAIL %s cyc=%0d due=%0d got=%h want=%h", sel_name(sb[i].sel), cyc,
                   sb[i].due, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, e);
    end
  endtask

  task automatic push(input int sel, input int lat, input logic [31:0] e);
    exp_t x;
    x.due = cyc + lat;
    x.sel = sel;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic exp_rd(input bit is_data, input logic [31:0] e);
    push(is_data ? 1 : 0, 1, e);
    push(is_data ? 3 : 2, 3, e);
  endtask

  task automatic exp_rdata_now(input logic [31:0] e);
    for (int s = 0; s < 4; s++) push(s, 0, e);
  endtask

  task automatic exp_ready(input logic b);
    push(4, 0, {31'b0, b});
    push(5, 0, {31'b0, b});
  endtask

  task automatic exp_err(input logic b);
    push(6, 0, {31'b0, b});
    push(7, 0, {31'b0, b});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_we    = 1'b0;
    data_we    = 1'b0;
    inst_addr  = BASE;
    data_addr  = BASE;
    inst_wdata = '0;
    data_wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (3) step();
    check_now("reset_ready_lat1", {31'b0, ready1}, 32'h0);
    check_now("reset_ready_lat3", {31'b0, ready3}, 32'h0);
    check_now("reset_err_lat1", {31'b0, err1}, 32'h0);
    check_now("reset_err_lat3", {31'b0, err3}, 32'h0);
    check_now("reset_inst_rdata_lat1", inst_rdata1, 32'h0);
    check_now("reset_data_rdata_lat1", data_rdata1, 32'h0);
    check_now("reset_inst_rdata_lat3", inst_rdata3, 32'h0);
    check_now("reset_data_rdata_lat3", data_rdata3, 32'h0);
    exp_ready(1'b0);
    exp_err(1'b0);
    exp_rdata_now(32'h0);
    reset = 1'b0;

    // Clear phase: 16 cycles not ready, rdata forced to 0, port write ignored.
    inst_addr = BASE + 32'h8;
    data_addr = BASE + 32'h8;
    for (int i = 0; i < 16; i++) begin
      exp_ready(1'b0);
      exp_rdata_now(32'h0);
      data_we    = (i == 3);
      data_wdata = 32'haaaa_5555;
      step();
    end
    data_we = 1'b0;
    exp_ready(1'b1);
    exp_err(1'b0);
    exp_rd(1'b0, 32'h0);
    exp_rd(1'b1, 32'h0);
    step();

    // Write then read on the other port next cycle.
    idle();
    data_we = 1'b1; data_addr = BASE + 32'h10; data_wdata = 32'hdead_beef;
    step();
    idle();
    inst_addr = BASE + 32'h10;
    data_addr = BASE + 32'h13;
    exp_rd(1'b0, 32'hdead_beef);
    exp_rd(1'b1, 32'hdead_beef);
    step();

    idle(); data_we = 1'b1; data_addr = BASE + 32'h0; data_wdata = 32'h11; step();
    idle(); data_we = 1'b1; data_addr = BASE + 32'h4; data_wdata = 32'h22; step();
    idle(); data_we = 1'b1; data_addr = BASE + 32'h8; data_wdata = 32'h33; step();

    // Back-to-back pipelined reads on both ports.
    idle(); inst_addr = BASE + 32'h0; data_addr = BASE + 32'h8;
    exp_rd(1'b0, 32'h11); exp_rd(1'b1, 32'h33); step();
    idle(); inst_addr = BASE + 32'h4; data_addr = BASE + 32'h4;
    exp_rd(1'b0, 32'h22); exp_rd(1'b1, 32'h22); step();
    idle(); inst_addr = BASE + 32'h8; data_addr = BASE + 32'h0;
    exp_rd(1'b0, 32'h33); exp_rd(1'b1, 32'h11); step();

    // Collision: both write word 0x20; reads see old value, data port wins.
    idle();
    inst_we = 1'b1; inst_addr = BASE + 32'h20; inst_wdata = 32'h2;
    data_we = 1'b1; data_addr = BASE + 32'h20; data_wdata = 32'h1;
    exp_rd(1'b0, 32'h0); exp_rd(1'b1, 32'h0);
    step();
    idle(); inst_addr = BASE + 32'h20; data_addr = BASE + 32'h20;
    exp_rd(1'b0, 32'h1); exp_rd(1'b1, 32'h1);
    step();

    // Inst-port write.
    idle(); inst_we = 1'b1; inst_addr = BASE + 32'h24; inst_wdata = 32'h77; step();
    idle(); data_addr = BASE + 32'h24; exp_rd(1'b1, 32'h77); exp_err(1'b0); step();

    // Out-of-range write is dropped, reads 0, and sets the sticky error.
    idle();
    data_we = 1'b1; data_addr = 32'h0000_0010; data_wdata = 32'hffff_ffff;
    exp_rd(1'b1, 32'h0);
    step();
    exp_err(1'b1);
    idle(); data_addr = BASE + 32'h10; inst_addr = BASE + 32'h40;
    exp_rd(1'b1, 32'hdead_beef); exp_rd(1'b0, 32'h0);
    step();
    idle();
    repeat (4) step();
    exp_err(1'b1);

    // Reset mid-run: flushes pipes, clears state, re-zeros the array.
    idle(); data_we = 1'b1; data_addr = BASE + 32'h4; data_wdata = 32'h5; step();
    idle();
    repeat (4) step();
    reset = 1'b1;
    step();
    exp_ready(1'b0);
    exp_err(1'b0);
    exp_rdata_now(32'h0);
    reset = 1'b0;
    repeat (16) step();
    exp_ready(1'b1);
    inst_addr = BASE + 32'h4; data_addr = BASE + 32'h4;
    exp_rd(1'b0, 32'h0); exp_rd(1'b1, 32'h0);
    step();
    idle();
    repeat (6) step();

    // Any expectation still queued was never compared: its wait expired.
    if (sb.size() != 0) begin
      bad += sb.size();
      for (int i = 0; i < sb.size(); i++) begin
        $display("FAIL expired %s due=%0d cyc=%0d", sel_name(sb[i].sel), sb[i].due, cyc);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("TEST PASSED");
    else $display("TEST FAILED");
    $finish;
  end

endmodule
